uv_rst_seq: RTL

UV_RST_SEQ -- requirements
Module: uv_rst_seq

---
 rtl/uv_rst_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/uv_rst_seq.sv
// uv_rst_seq: power-on / system reset sequencer with lock, LDO, button and soft-reset handling
module uv_rst_seq #(
  parameter int LOCK_CYCLES   = 16,
  parameter int STAGE_GAP     = 4,
  parameter int BTN_DB_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_locked,
  input  logic       btn_rst_n,
  input  logic       soft_rst_req,
  input  logic       ldo_ready,
  output logic       por_rst_n,
  output logic       sys_rst_n,
  output logic [1:0] rst_cause,
  output logic       seq_busy
);
  localparam logic [2:0] S_LOCK = 3'd0;
  localparam logic [2:0] S_POR  = 3'd1;
  localparam logic [2:0] S_LDO  = 3'd2;
  localparam logic [2:0] S_SYS  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;
  localparam logic [7:0] LOCK_L = 8'(LOCK_CYCLES - 1);
  localparam logic [7:0] GAP_L  = 8'(STAGE_GAP - 1);
  localparam logic [7:0] DB_L   = 8'(BTN_DB_CYCLES);
  logic [2:0] state, nxt_state;
  logic [7:0] cnt, nxt_cnt, db_cnt, nxt_db;
  logic       nxt_por, nxt_sys, press;
  logic [1:0] nxt_cause;
  // next-state, shared counter and reset-output decisions; lock loss outranks everything
  always_comb begin
    press     = db_cnt == DB_L;
    nxt_db    = btn_rst_n ? 8'd0 : (press ? db_cnt : db_cnt + 8'd1);
    nxt_state = state;
    nxt_cnt   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    nxt_por   = por_rst_n;
    nxt_sys   = sys_rst_n;
    nxt_cause = rst_cause;
    if (state == S_LOCK) begin
      if (!clk_locked) nxt_cnt = 8'd0;
      else if (cnt == LOCK_L) begin
        nxt_state = S_POR;
        nxt_cnt   = 8'd0;
        nxt_por   = 1'b1;
      end
    end else if (!clk_locked) begin
      nxt_state = S_LOCK;
      nxt_cnt   = 8'd0;
      nxt_por   = 1'b0;
      nxt_sys   = 1'b0;
      nxt_cause = 2'b01;
    end else begin
      case (state)
        S_POR: if (cnt == GAP_L) begin
          nxt_state = S_LDO;
          nxt_cnt   = 8'd0;
        end
        S_LDO: if (ldo_ready) begin
          nxt_state = S_SYS;
          nxt_cnt   = 8'd0;
        end
        S_SYS: if (cnt == GAP_L) begin
          nxt_state = S_RUN;
          nxt_cnt   = 8'd0;
          nxt_sys   = 1'b1;
        end
        S_RUN: if (press || soft_rst_req) begin
          nxt_state = S_HOLD;
          nxt_cnt   = 8'd0;
          nxt_sys   = 1'b0;
          nxt_cause = press ? 2'b10 : 2'b11;
        end
        S_HOLD: if (cnt >= GAP_L && btn_rst_n) begin
          nxt_state = S_SYS;
          nxt_cnt   = 8'd0;
        end
        default: begin
          nxt_state = S_LOCK;
          nxt_cnt   = 8'd0;
          nxt_por   = 1'b0;
          nxt_sys   = 1'b0;
        end
      endcase
    end
  end
  // state and registered outputs; busy is derived from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOCK;
      cnt       <= 8'd0;
      db_cnt    <= 8'd0;
      por_rst_n <= 1'b0;
      sys_rst_n <= 1'b0;
      rst_cause <= 2'b00;
      seq_busy  <= 1'b1;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      db_cnt    <= nxt_db;
      por_rst_n <= nxt_por;
      sys_rst_n <= nxt_sys;
      rst_cause <= nxt_cause;
      seq_busy  <= nxt_state != S_RUN;
    end
  end
endmodule
